pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage LEGv8 core. It pairs with the forwarding unit and handles the hazards forwarding cannot cover: load-use stalls, taken-branch flushes, and data-memory wait states. Each cycle it drives the per-stage register enables and flushes plus the PC branch select. It also keeps saturating stall and flush counters and a sticky memory-timeout error.

---
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// data-memory wait freezes, saturating event counters and a sticky timeout.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memrd,
    input  logic             ex_regwr,
    input  logic             br_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             pc_sel_br,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic mem_block;
    logic freeze;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    assign mem_block = dmem_req & ~dmem_ready;
    assign freeze    = mem_block | (state_q == ERROR);
    assign load_use  = ex_memrd & ex_regwr & (ex_rd != 5'd31) &
                       ((id_uses_rn & (id_rn == ex_rd)) |
                        (id_uses_rm & (id_rm == ex_rd)));

    // Control outputs: freeze > branch > load-use > normal
    always_comb begin
        pc_en        = 1'b1;
        pc_sel_br    = 1'b0;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (br_taken_ex) begin
            pc_sel_br  = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign stall_inc = (freeze & (state_q != ERROR)) |
                       (~freeze & ~br_taken_ex & load_use);
    assign flush_inc = ~freeze & br_taken_ex;

    // Next state, wait counter and saturating event counters
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        stall_d = stall_q;
        flush_d = flush_q;
        case (state_q)
            RUN: begin
                wait_d = '0;
                if (mem_block) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_block) begin
                    if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) state_d = ERROR;
                    else wait_d = wait_q + WAIT_W'(1);
                end else begin
                    state_d = RUN;
                    wait_d  = '0;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase
        if (stall_inc && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
        if (flush_inc && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
    assign err       = (state_q == ERROR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       id_uses_rn, id_uses_rm, ex_memrd, ex_regwr;
    logic       br_taken_ex, dmem_req, dmem_ready;

    logic        pc_en, pc_sel_br, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, memwb_bubble, err;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_pc_sel_br, s_ifid_en, s_idex_en, s_exmem_en;
    logic        s_ifid_flush, s_idex_flush, s_memwb_bubble, s_err;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // {pc_en, pc_sel_br, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
    localparam logic [7:0] NORM = 8'b1011_1000;
    localparam logic [7:0] FRZ  = 8'b0000_0001;
    localparam logic [7:0] BR   = 8'b1111_1110;
    localparam logic [7:0] LU   = 8'b0001_1010;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(16), .TIMEOUT(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .ex_rd(ex_rd), .ex_memrd(ex_memrd), .ex_regwr(ex_regwr),
        .br_taken_ex(br_taken_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .pc_sel_br(pc_sel_br), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .err(err)
    );

    pipe_hazard_ctrl #(.CNT_W(2), .TIMEOUT(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .ex_rd(ex_rd), .ex_memrd(ex_memrd), .ex_regwr(ex_regwr),
        .br_taken_ex(br_taken_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(s_pc_en), .pc_sel_br(s_pc_sel_br), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
        .exmem_en(s_exmem_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .memwb_bubble(s_memwb_bubble), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
        .err(s_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, pc_en, pc_sel_br, ifid_en, idex_en, exmem_en,
                  ifid_flush, idex_flush, memwb_bubble}, {24'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input int stl, input int fl, input logic e);
        chk({tag, "_stall"}, {16'd0, stall_cnt}, stl);
        chk({tag, "_flush"}, {16'd0, flush_cnt}, fl);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
    endtask

    task automatic set_in(input logic br, input logic req, input logic rdy,
                          input logic memrd, input logic regwr, input logic [4:0] rd,
                          input logic [4:0] rn, input logic urn,
                          input logic [4:0] rm, input logic urm);
        br_taken_ex = br; dmem_req = req; dmem_ready = rdy;
        ex_memrd = memrd; ex_regwr = regwr; ex_rd = rd;
        id_rn = rn; id_uses_rn = urn; id_rm = rm; id_uses_rm = urm;
        #1;
    endtask

    // advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        #2;
        chk_cnt("reset", 0, 0, 1'b0);
        chk_ctl("reset_ctl", NORM);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        chk_ctl("idle", NORM);
        tick();

        // Load-use on Rn, then EX holds the bubble
        set_in(0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        chk_ctl("lu_rn", LU);
        tick();
        chk_cnt("lu_rn", 1, 0, 1'b0);
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0);
        chk_ctl("lu_bubble", NORM);
        tick();
        chk_cnt("lu_bubble", 1, 0, 1'b0);

        // Load-use on Rm; same regs with uses_rm low is not a hazard
        set_in(0, 0, 0, 1, 1, 5'd7, 5'd1, 1, 5'd7, 1);
        chk_ctl("lu_rm", LU);
        tick();
        set_in(0, 0, 0, 1, 1, 5'd7, 5'd1, 1, 5'd7, 0);
        chk_ctl("lu_rm_unused", NORM);
        tick();
        chk_cnt("lu_rm", 2, 0, 1'b0);

        // X31 and non-writing load never stall
        set_in(0, 0, 0, 1, 1, 5'd31, 5'd31, 1, 5'd31, 1);
        chk_ctl("lu_x31", NORM);
        tick();
        set_in(0, 0, 0, 1, 0, 5'd5, 5'd5, 1, 5'd0, 0);
        chk_ctl("lu_noregwr", NORM);
        tick();
        chk_cnt("lu_x31", 2, 0, 1'b0);

        // Branch beats load-use
        set_in(1, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        chk_ctl("br_lu", BR);
        tick();
        chk_cnt("br_lu", 2, 1, 1'b0);

        // 3-cycle memory wait then advance
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
            chk_ctl($sformatf("memwait%0d", i), FRZ);
            tick();
        end
        set_in(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        chk_ctl("memwait_ready", NORM);
        tick();
        chk_cnt("memwait", 5, 1, 1'b0);
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        chk_ctl("memwait_run", NORM);
        tick();

        // Branch held through a 2-cycle wait
        for (int i = 0; i < 2; i++) begin
            set_in(1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
            chk_ctl($sformatf("brwait%0d", i), FRZ);
            tick();
        end
        set_in(1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        chk_ctl("brwait_ready", BR);
        tick();
        chk_cnt("brwait", 7, 2, 1'b0);
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();

        // Timeout: RUN freeze cycle + 4 MEM_WAIT cycles, then ERROR
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
            chk_ctl($sformatf("to_frz%0d", i), FRZ);
            if (i == 4) chk("to_err_pre", {31'd0, err}, 32'd0);
            tick();
        end
        chk_cnt("to_err", 12, 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
            chk_ctl($sformatf("err_hold%0d", i), FRZ);
            tick();
        end
        chk_cnt("err_hold", 12, 2, 1'b1);

        // Reset out of ERROR
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt("rst_err", 0, 0, 1'b0);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        chk_ctl("rst_err_ctl", NORM);
        tick();

        // Five load-use stalls: 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 1, 1, 5'd9, 5'd0, 0, 5'd9, 1);
            tick();
            set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
            tick();
        end
        chk("sat_stall", {30'd0, s_stall_cnt}, 32'd3);
        chk("wide_stall", {16'd0, stall_cnt}, 32'd5);
        chk("sat_flush", {30'd0, s_flush_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
